// File: rtl/bit_replacer_n.sv
// Bit-stream replacer: walks the video word stream MSB-first and, per command,
// skips a gap of bits then overwrites PAY_W payload bits plus an optional complementary extend bit.
module bit_replacer_n #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 7,
   parameter int PAY_W  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic [DATA_W-1:0] vid_in,
   input  logic              vid_empty,
   output logic              vid_rd,
   input  logic [CNT_W-1:0]  cnt_in,
   input  logic              sign_flag,
   input  logic              extend_flag,
   input  logic              cnt_empty,
   output logic              cnt_rd,
   input  logic [PAY_W-1:0]  sign_in,
   input  logic              sign_empty,
   output logic              sign_rd,
   input  logic              out_afull,
   output logic [DATA_W-1:0] data_out,
   output logic              data_wr
);
   localparam int PW = $clog2(DATA_W + 1);
   localparam int KW = $clog2(PAY_W + 1);
   localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
   localparam int CW = CNT_W + 2;

   typedef enum logic [1:0] {S_CMD, S_SKIP, S_INS, S_EXT} state_t;

   logic              module_en, run_q, emit;
   logic              vid_pend_q, vid_hv_q, vid_av, vid_take;
   logic [DATA_W-1:0] vid_h_q, vid_dat;
   logic              cmd_pend_q, cmd_hv_q, cmd_av, cmd_take;
   logic [CW-1:0]     cmd_h_q, cmd_dat;
   logic              sgn_pend_q, sgn_hv_q, sgn_av, sgn_take;
   logic [PAY_W-1:0]  sgn_h_q, sgn_dat, pay_sh;
   state_t            state_q, state_d;
   logic [DATA_W-1:0] wreg_q, wreg_d, cur_w, dout_q, dout_d, msk;
   logic              wv_q, wv_d, cur_v;
   logic [PW-1:0]     pos_q, pos_d, cur_pos;
   logic [CNT_W-1:0]  gap_q, gap_d;
   logic              sf_q, sf_d, ef_q, ef_d, last_q, last_d, pay_bit, can_bit;
   logic [KW-1:0]     k_q, k_d;
   logic [SW-1:0]     room, gap_w, step;

   assign module_en = clk_en & ~out_afull;
   assign emit      = wv_q && (pos_q == PW'(DATA_W));

   // Holding registers are bypassed while their read data is still on the bus
   assign vid_av  = vid_hv_q | vid_pend_q;
   assign vid_dat = vid_hv_q ? vid_h_q : vid_in;
   assign cmd_av  = cmd_hv_q | cmd_pend_q;
   assign cmd_dat = cmd_hv_q ? cmd_h_q : {sign_flag, extend_flag, cnt_in};
   assign sgn_av  = sgn_hv_q | sgn_pend_q;
   assign sgn_dat = sgn_hv_q ? sgn_h_q : sign_in;

   assign vid_rd  = module_en & run_q & ~rst & ~vid_empty  & (~vid_av | vid_take);
   assign cnt_rd  = module_en & run_q & ~rst & ~cnt_empty  & (~cmd_av | cmd_take);
   assign sign_rd = module_en & run_q & ~rst & ~sign_empty & (~sgn_av | sgn_take);

   assign data_wr  = module_en & emit;
   assign data_out = emit ? wreg_q : dout_q;

   // Word the FSM works on this cycle: a fresh word replaces an emitted or absent one
   always_comb begin
      vid_take = 1'b0;
      cur_v    = wv_q;
      cur_pos  = pos_q;
      cur_w    = wreg_q;
      if (module_en && (emit || !wv_q)) begin
         cur_pos  = '0;
         cur_v    = vid_av;
         cur_w    = vid_av ? vid_dat : wreg_q;
         vid_take = vid_av;
      end
   end

   assign room    = SW'(DATA_W) - SW'(cur_pos);
   assign gap_w   = SW'(gap_q);
   assign step    = (gap_w < room) ? gap_w : room;
   assign msk     = {1'b1, {(DATA_W-1){1'b0}}} >> cur_pos;
   assign pay_sh  = sgn_dat << k_q;
   assign pay_bit = pay_sh[PAY_W-1];
   assign can_bit = module_en && cur_v && (cur_pos != PW'(DATA_W));

   always_comb begin
      state_d  = state_q;
      wreg_d   = cur_w;
      wv_d     = cur_v;
      pos_d    = cur_pos;
      gap_d    = gap_q;
      sf_d     = sf_q;
      ef_d     = ef_q;
      k_d      = k_q;
      last_d   = last_q;
      dout_d   = dout_q;
      cmd_take = 1'b0;
      sgn_take = 1'b0;
      if (module_en && emit) dout_d = wreg_q;
      if (module_en) begin
         unique case (state_q)
            S_CMD: if (cmd_av) begin
               cmd_take = 1'b1;
               gap_d    = cmd_dat[CNT_W-1:0];
               sf_d     = cmd_dat[CNT_W+1];
               ef_d     = cmd_dat[CNT_W+1] & cmd_dat[CNT_W];
               k_d      = '0;
               if (cmd_dat[CNT_W-1:0] != '0) state_d = S_SKIP;
               else if (cmd_dat[CNT_W+1])    state_d = S_INS;
            end
            S_SKIP: if (can_bit) begin
               pos_d = cur_pos + PW'(step);
               gap_d = gap_q - CNT_W'(step);
               if (gap_w == step) state_d = sf_q ? S_INS : S_CMD;
            end
            S_INS: if (can_bit && sgn_av) begin
               wreg_d = pay_bit ? (cur_w | msk) : (cur_w & ~msk);
               pos_d  = cur_pos + PW'(1);
               if (k_q == KW'(PAY_W - 1)) begin
                  sgn_take = 1'b1;
                  k_d      = '0;
                  last_d   = pay_bit;
                  state_d  = ef_q ? S_EXT : S_CMD;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
            S_EXT: if (can_bit) begin
               wreg_d  = last_q ? (cur_w & ~msk) : (cur_w | msk);
               pos_d   = cur_pos + PW'(1);
               state_d = S_CMD;
            end
            default: state_d = S_CMD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q      <= 1'b0;
         state_q    <= S_CMD;
         wreg_q     <= '0;
         wv_q       <= 1'b0;
         pos_q      <= '0;
         gap_q      <= '0;
         sf_q       <= 1'b0;
         ef_q       <= 1'b0;
         k_q        <= '0;
         last_q     <= 1'b0;
         dout_q     <= '0;
         vid_pend_q <= 1'b0;
         vid_hv_q   <= 1'b0;
         vid_h_q    <= '0;
         cmd_pend_q <= 1'b0;
         cmd_hv_q   <= 1'b0;
         cmd_h_q    <= '0;
         sgn_pend_q <= 1'b0;
         sgn_hv_q   <= 1'b0;
         sgn_h_q    <= '0;
      end else begin
         run_q      <= 1'b1;
         state_q    <= state_d;
         wreg_q     <= wreg_d;
         wv_q       <= wv_d;
         pos_q      <= pos_d;
         gap_q      <= gap_d;
         sf_q       <= sf_d;
         ef_q       <= ef_d;
         k_q        <= k_d;
         last_q     <= last_d;
         dout_q     <= dout_d;
         vid_pend_q <= vid_rd;
         cmd_pend_q <= cnt_rd;
         sgn_pend_q <= sign_rd;
         // Read data that is not consumed on arrival is parked, even while stalled
         if (vid_take) vid_hv_q <= 1'b0;
         else if (vid_pend_q) begin
            vid_hv_q <= 1'b1;
            vid_h_q  <= vid_in;
         end
         if (cmd_take) cmd_hv_q <= 1'b0;
         else if (cmd_pend_q) begin
            cmd_hv_q <= 1'b1;
            cmd_h_q  <= {sign_flag, extend_flag, cnt_in};
         end
         if (sgn_take) sgn_hv_q <= 1'b0;
         else if (sgn_pend_q) begin
            sgn_hv_q <= 1'b1;
            sgn_h_q  <= sign_in;
         end
      end
   end
endmodule

// File: tb/tb_bit_replacer_n.sv
// Scoreboard bench for bit_replacer_n: two instances (PAY_W=1 and PAY_W=2) fed from queue FIFOs,
// expected words produced by a flat bit-array model of the command stream.
module tb_bit_replacer_n;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, clk_en, out_afull;
   logic [7:0] vid_bus [2];
   logic       vid_empty [2], vid_rd [2];
   logic [8:0] cmd_bus [2];
   logic       cmd_empty [2], cmd_rd [2];
   logic [1:0] sgn_bus [2];
   logic       sgn_empty [2], sign_rd [2];
   logic [7:0] dout [2];
   logic       dwr [2];

   logic [7:0] vid_q [2][$];
   logic [8:0] cmd_q [2][$];
   logic [1:0] sgn_q [2][$];
   logic [7:0] exp_q [2][$];
   logic [7:0] sw [$];
   logic [8:0] sc [$];
   logic [1:0] sp [$];

   int         total = 0;
   int         passed = 0;
   int         wr_cnt [2];
   logic [7:0] last_wr [2];

   bit_replacer_n #(.DATA_W(8), .CNT_W(7), .PAY_W(1)) u0 (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .vid_in(vid_bus[0]), .vid_empty(vid_empty[0]), .vid_rd(vid_rd[0]),
      .cnt_in(cmd_bus[0][6:0]), .sign_flag(cmd_bus[0][8]), .extend_flag(cmd_bus[0][7]),
      .cnt_empty(cmd_empty[0]), .cnt_rd(cmd_rd[0]),
      .sign_in(sgn_bus[0][0:0]), .sign_empty(sgn_empty[0]), .sign_rd(sign_rd[0]),
      .out_afull(out_afull), .data_out(dout[0]), .data_wr(dwr[0]));

   bit_replacer_n #(.DATA_W(8), .CNT_W(7), .PAY_W(2)) u1 (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .vid_in(vid_bus[1]), .vid_empty(vid_empty[1]), .vid_rd(vid_rd[1]),
      .cnt_in(cmd_bus[1][6:0]), .sign_flag(cmd_bus[1][8]), .extend_flag(cmd_bus[1][7]),
      .cnt_empty(cmd_empty[1]), .cnt_rd(cmd_rd[1]),
      .sign_in(sgn_bus[1]), .sign_empty(sgn_empty[1]), .sign_rd(sign_rd[1]),
      .out_afull(out_afull), .data_out(dout[1]), .data_wr(dwr[1]));

   function automatic int pw(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Model: splice the staged words into one bit stream, apply commands, cut back into words
   task automatic commit(input int i);
      logic       b [$];
      logic [7:0] w;
      logic [1:0] p;
      logic       lastb;
      int         cur, pi;
      b = {};
      foreach (sw[k]) for (int j = 7; j >= 0; j--) b.push_back(sw[k][j]);
      cur = 0;
      pi = 0;
      lastb = 1'b0;
      foreach (sc[k]) begin
         cur += int'(sc[k][6:0]);
         if (sc[k][8]) begin
            p = sp[pi];
            pi++;
            for (int j = 0; j < pw(i); j++) begin
               lastb = p[pw(i)-1-j];
               b[cur] = lastb;
               cur++;
            end
            if (sc[k][7]) begin
               b[cur] = ~lastb;
               cur++;
            end
         end
      end
      for (int k = 0; k < sw.size(); k++) begin
         for (int j = 0; j < 8; j++) w[7-j] = b[k*8+j];
         exp_q[i].push_back(w);
      end
      foreach (sw[k]) vid_q[i].push_back(sw[k]);
      foreach (sc[k]) cmd_q[i].push_back(sc[k]);
      foreach (sp[k]) sgn_q[i].push_back(sp[k]);
      sw = {};
      sc = {};
      sp = {};
   endtask

   task automatic gen_random(input int i);
      int n, r, g, maxg, e;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) sw.push_back(8'($urandom));
      r = n * 8;
      while (r > 0) begin
         if ($urandom_range(0, 1) == 1 && r >= pw(i)) begin
            e = (r >= pw(i) + 1) ? int'($urandom_range(0, 1)) : 0;
            maxg = r - pw(i) - e;
            if (maxg > 127) maxg = 127;
            g = $urandom_range(0, maxg);
            sc.push_back({1'b1, e[0], g[6:0]});
            sp.push_back(2'($urandom));
            r -= g + pw(i) + e;
         end else begin
            maxg = (r > 127) ? 127 : r;
            g = $urandom_range(0, maxg);
            sc.push_back({1'b0, 1'($urandom), g[6:0]});
            r -= g;
         end
      end
      commit(i);
   endtask

   task automatic wait_drain(input bit rnd);
      int cyc = 0;
      while ((exp_q[0].size() + exp_q[1].size()) != 0 && cyc < 3000) begin
         @(posedge clk); #1;
         if (rnd) begin
            clk_en = ($urandom_range(0, 3) != 0);
            out_afull = ($urandom_range(0, 4) == 0);
         end
         cyc++;
      end
      clk_en = 1'b1;
      out_afull = 1'b0;
      chk("drain_left", exp_q[0].size() + exp_q[1].size(), 0);
      exp_q[0].delete();
      exp_q[1].delete();
      repeat (3) @(posedge clk);
      #1;
   endtask

   // FIFO models: data appears the cycle after the read strobe
   initial begin
      logic rv [2], rc [2], rs [2];
      for (int i = 0; i < 2; i++) begin
         vid_bus[i] = '0; cmd_bus[i] = '0; sgn_bus[i] = '0;
         vid_empty[i] = 1'b1; cmd_empty[i] = 1'b1; sgn_empty[i] = 1'b1;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            rv[i] = vid_rd[i]; rc[i] = cmd_rd[i]; rs[i] = sign_rd[i];
         end
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            if (rv[i] && vid_q[i].size() != 0) vid_bus[i] = vid_q[i].pop_front();
            if (rc[i] && cmd_q[i].size() != 0) cmd_bus[i] = cmd_q[i].pop_front();
            if (rs[i] && sgn_q[i].size() != 0) sgn_bus[i] = sgn_q[i].pop_front();
            vid_empty[i] = (vid_q[i].size() == 0);
            cmd_empty[i] = (cmd_q[i].size() == 0);
            sgn_empty[i] = (sgn_q[i].size() == 0);
         end
      end
   end

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (dwr[i]) begin
               wr_cnt[i]++;
               last_wr[i] = dout[i];
               if (exp_q[i].size() == 0) begin
                  total++;
                  $display("FAIL unexpected_wr inst%0d: got 0x%0h, expected no write", i, dout[i]);
               end else begin
                  chk($sformatf("data_out_inst%0d", i), int'(dout[i]), int'(exp_q[i].pop_front()));
               end
            end
         end
      end
   end

   initial begin
      int w0, cyc;
      logic [7:0] held;
      wr_cnt[0] = 0; wr_cnt[1] = 0;
      last_wr[0] = '0; last_wr[1] = '0;
      rst = 1'b1; clk_en = 1'b1; out_afull = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_strobes%0d", i), int'({vid_rd[i], cmd_rd[i], sign_rd[i], dwr[i]}), 0);
         chk($sformatf("rst_dout%0d", i), int'(dout[i]), 0);
      end
      @(posedge clk); #1 rst = 1'b0;

      // Test 1
      sw = {8'hFF}; sc = {9'h103, 9'h004}; sp = {2'b00};
      w0 = wr_cnt[0]; commit(0); wait_drain(0);
      chk("t1_word", int'(last_wr[0]), 'hEF);
      chk("t1_count", wr_cnt[0] - w0, 1);
      // Test 2
      sw = {8'h00}; sc = {9'h186}; sp = {2'b01};
      w0 = wr_cnt[0]; commit(0); wait_drain(0);
      chk("t2_word", int'(last_wr[0]), 'h02);
      chk("t2_count", wr_cnt[0] - w0, 1);
      // Test 3
      sw = {8'hFF, 8'hFF}; sc = {9'h187, 9'h007}; sp = {2'b01};
      w0 = wr_cnt[0]; commit(0); wait_drain(0);
      chk("t3_word", int'(last_wr[0]), 'h7F);
      chk("t3_count", wr_cnt[0] - w0, 2);
      // Test 4
      sw = {8'h00}; sc = {9'h102, 9'h004}; sp = {2'b11};
      w0 = wr_cnt[1]; commit(1); wait_drain(0);
      chk("t4_word", int'(last_wr[1]), 'h30);
      chk("t4_count", wr_cnt[1] - w0, 1);
      // Test 5: long gap with output backpressure mid-run
      sw = {8'h12, 8'h34, 8'h56}; sc = {9'h014, 9'h004}; sp = {};
      w0 = wr_cnt[0]; commit(0);
      cyc = 0;
      while (wr_cnt[0] == w0 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("t5_first_wr", int'(wr_cnt[0] != w0), 1);
      out_afull = 1'b1;
      @(negedge clk);
      held = dout[0];
      for (int c = 0; c < 5; c++) begin
         if (c != 0) @(negedge clk);
         chk("t5_afull_strobes", int'({vid_rd[0], cmd_rd[0], sign_rd[0], dwr[0]}), 0);
         chk("t5_afull_dout", int'(dout[0]), int'(held));
      end
      @(posedge clk); #1 out_afull = 1'b0;
      wait_drain(0);
      chk("t5_word", int'(last_wr[0]), 'h56);
      chk("t5_count", wr_cnt[0] - w0, 3);
      // Test 6: reset while a word is partly resolved
      vid_q[0].push_back(8'hFF);
      cmd_q[0].push_back(9'h103);
      w0 = wr_cnt[0];
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      sw = {8'hFF}; sc = {9'h103, 9'h004}; sp = {2'b00};
      commit(0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("t6_post_rst_strobes", int'({vid_rd[0], cmd_rd[0], sign_rd[0], dwr[0]}), 0);
      chk("t6_post_rst_dout", int'(dout[0]), 0);
      chk("t6_no_wr", wr_cnt[0] - w0, 0);
      wait_drain(0);
      chk("t6_word", int'(last_wr[0]), 'hEF);
      chk("t6_count", wr_cnt[0] - w0, 1);
      // Randomized transactions on both instances with random stalls
      for (int r = 0; r < 24; r++) begin
         gen_random(r % 2);
         if (r % 4 == 3) wait_drain(1);
      end
      wait_drain(1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/bit_replacer_n.md
Name: bit_replacer_n

Overview:
- Parametrised successor to the single-bit sign replacer in the video embedding path.
- Treats the incoming video word stream as one continuous bit stream, MSB of each word first.
- A command FIFO supplies {sign_flag, extend_flag, gap}. Each command skips gap bits unchanged, then optionally overwrites PAY_W bits with a payload word, optionally followed by one complementary extend bit.
- Words may be crossed by any command. The block sits between the video FIFO and the output FIFO, beside the count and sign FIFOs.

Parameters:
- DATA_W, 8: video word width in bits, 2..32.
- CNT_W, 7: width of gap field; max gap 2^CNT_W-1.
- PAY_W, 1: payload bits written per insertion, 1..DATA_W.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- clk_en  in  1  global clock enable.
- vid_in  in  DATA_W  video word, valid the cycle after vid_rd.
- vid_empty  in  1  video FIFO empty.
- vid_rd  out  1  video FIFO read strobe.
- cnt_in  in  CNT_W  gap field, valid the cycle after cnt_rd.
- sign_flag  in  1  command inserts payload; valid with cnt_in.
- extend_flag  in  1  command appends extend bit; ignored unless sign_flag; valid with cnt_in.
- cnt_empty  in  1  command FIFO empty.
- cnt_rd  out  1  command FIFO read strobe.
- sign_in  in  PAY_W  payload word, valid the cycle after sign_rd.
- sign_empty  in  1  payload FIFO empty.
- sign_rd  out  1  payload FIFO read strobe.
- out_afull  in  1  output FIFO almost full.
- data_out  out  DATA_W  modified video word.
- data_wr  out  1  output write strobe, one cycle per word.

Behaviour:
- Reset and clocking:
  - Single clock. Reset is synchronous and active-high.
  - Reset clears all state; data_wr, vid_rd, cnt_rd, sign_rd and data_out are 0 in the cycle after rst is sampled high.
- Enable:
  - module_en = clk_en & ~out_afull.
  - When module_en=0: state frozen, all rd strobes 0, data_wr 0, data_out held.
- Read interface:
  - A read strobe is issued only when the matching empty flag is 0 and module_en=1.
  - Read data is captured the following cycle into a one-entry holding register per stream (vid, cmd, sign).
  - The next read may be issued in the same cycle the holding register is consumed, giving zero bubble.
- Word register and cursor:
  - wreg holds the current word; pos (0..DATA_W) is the number of its bits already resolved, counted from the MSB.
  - wreg loads from the vid holding register when empty, or in the cycle the current word is emitted.
- FSM states:
  - CMD: wait for a command in the cmd holding register, then load gap_rem=cnt_in and the flags.
    - gap=0 with sign_flag=0 is a no-op, consumed in 1 cycle.
    - gap=0 with sign_flag=1 goes straight to INS.
  - SKIP: per cycle advance pos and decrement gap_rem by min(gap_rem, DATA_W-pos).
    - At gap_rem=0, go to INS if sign_flag, else to CMD.
  - INS: per cycle, if a payload word is held and pos<DATA_W, write payload bit (PAY_W-1-k) into wreg bit (DATA_W-1-pos), pos++, k++.
    - After PAY_W bits, go to EXT if extend_flag, else to CMD; release the sign holding register.
    - The last payload bit is remembered.
  - EXT: write ~last payload bit at the cursor, pos++, then go to CMD.
- Stalls:
  - If pos=DATA_W in SKIP, INS or EXT, the state waits for the next word.
  - INS waits while the sign holding register is empty.
- Word emission:
  - When pos reaches DATA_W, the next enabled cycle drives data_out=wreg and data_wr=1. This is 1 cycle of latency after the last bit is resolved.
  - In the same cycle, pos is cleared and the next word is loaded if one is held.
  - A word is never emitted until all of its bits are resolved by commands; the command stream must cover every bit.
- Throughput: one word per cycle in pure skip runs; 1 bit per cycle for inserted and extend bits.
- Widths: gap_rem is CNT_W bits; the step is min(...) with pos widened to CNT_W+1 bits; there is no wrap.
- Reset mid-operation: partial words, pending commands and held payloads are discarded and no write occurs. Words already read from the FIFOs are lost.

Test Plan:
1. DATA_W=8: vid 0xFF; cmd gap=3 sign=1 ext=0 payload 0; cmd gap=4 sign=0 -> single write data_out=0xEF.
2. vid 0x00; cmd gap=6 sign=1 ext=1 payload 1 -> data_out=0x02, one write.
3. Cross-boundary: vid 0xFF,0xFF; cmd gap=7 sign=1 ext=1 payload 1; cmd gap=7 sign=0 -> writes 0xFF then 0x7F.
4. PAY_W=2 instance: vid 0x00; cmd gap=2 sign=1 ext=0 payload 2'b11; cmd gap=4 -> data_out=0x30.
5. Long gap: vid 0x12,0x34,0x56; cmd gap=20 sign=0; cmd gap=4 -> writes 0x12,0x34,0x56 unmodified; no rd or wr strobes while out_afull is held for 5 cycles mid-run; output unchanged after release.
6. Assert rst for 1 cycle mid-word with pos=3 -> no data_wr; all strobes 0 next cycle; a fresh test-1 sequence afterwards yields 0xEF.
